glitch_sequencer: RTL and testbench
===================================

# glitch_sequencer

Parametrised, runtime-programmable successor to the single-shot glitch generator, running in the PLL clock domain of the fault-injection board. After being armed, it waits for a selectable trigger edge, counts a programmable delay, then emits a train of 1 to N glitch pulses with programmable width and inter-pulse gap. Config is latched at arm time so the host can reprogram freely while a sequence runs. Handshake status (armed, busy, done) replaces the fixed LED indicators.

## Interface
- CNT_W, 32: width of the delay, width and gap counters and config fields.
- PCNT_W, 8: width of the pulse-count field; max train length is 2^PCNT_W − 1.
- SYNC_STAGES, 2: trigger synchroniser depth, minimum 2.

- clk  in  1  PLL core clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  single-cycle request: latch config and wait for trigger
- abort  in  1  single-cycle request: cancel any activity and return to IDLE
- cfg_delay  in  CNT_W  cycles from trigger edge detect to first pulse
- cfg_width  in  CNT_W  pulse high time in cycles; 0 is treated as 1
- cfg_gap  in  CNT_W  low time between pulses in cycles; 0 is treated as 1
- cfg_count  in  PCNT_W  number of pulses; 0 is treated as 1
- cfg_edge  in  1  0 = rising trigger edge, 1 = falling trigger edge
- cfg_invert  in  1  1 = glitch output is active-low
- trigger  in  1  asynchronous external trigger
- glitch  out  1  registered glitch output
- armed  out  1  high in ARMED
- busy  out  1  high in DELAY, PULSE, GAP
- done  out  1  sticky completion flag

## Operation
- States are IDLE, ARMED, DELAY, PULSE, GAP.
- IDLE: on arm, latch all cfg_* (zero-to-one substitution applied at latch), clear done, go to ARMED. arm is ignored in every other state.
- ARMED: the edge detector compares the last two synchroniser outputs. On the selected edge, load the delay counter with cfg_delay and go to DELAY; if the latched delay is 0, go directly to PULSE.
- DELAY: decrement; leaving at count 1 gives exactly cfg_delay cycles, then go to PULSE.
- PULSE: glitch is active for exactly width cycles, then the pulse counter decrements. If pulses remain, go to GAP; otherwise set done and go to IDLE.
- GAP: glitch is inactive for exactly gap cycles, then go to PULSE.
- Edges arriving in any state other than ARMED are ignored. Each arm yields at most one sequence; there is no retrigger.
- abort in any state: go to IDLE and drive glitch inactive on the next cycle. done is not set and is left as it was. abort beats arm in the same cycle.
- Active level of glitch is cfg_invert latched at arm. In IDLE, glitch sits at the inactive level of the last latched cfg_invert (0 after reset).
- Counter arithmetic is unsigned CNT_W bits and never wraps; the counters only load and decrement to 1.

## Timing
- Reset values: state IDLE, glitch 0, armed 0, busy 0, done 0. The synchroniser stages reset to 0, so a trigger held high through reset does not produce a rising edge.
- Reset mid-sequence: glitch is 0 on the cycle after rst is sampled high.
- Latency: let k be the clk edge at which trigger is first sampled at its new level. With SYNC_STAGES = 2:
  - edge is detected at k+2;
  - glitch goes active at edge k+3+cfg_delay;
  - glitch stays active for width cycles, then is inactive for gap cycles, repeating.
- arm sampled at edge a: armed = 1 from a+1. done, armed and busy are registered and mutually exclusive.
- done rises on the same edge at which glitch goes inactive after the last pulse.
- Minimum pulse period is 2 cycles (width 1, gap 1).

## Structure
- Package glitch_pkg holds:
  - typedef enum for state, with IDLE = 0;
  - EDGE_RISE and EDGE_FALL constants;
  - a function clamp1() implementing the 0→1 substitution.
- Sub-module trig_sync (SYNC_STAGES, reset-to-0 flop chain plus edge detector). It outputs rise and fall strobes, each one cycle wide.
- The PLL primitive stays at board top level; this block only receives clk.

## Test plan
- Basic sequence: rst, arm with delay=10, width=3, count=1, trigger rises at edge k → glitch high on edges k+13 through k+15, done at k+16, busy low.
- Pulse train: count=4, width=2, gap=5 → exactly 4 pulses, period 7; done follows the 4th falling edge; total active cycles = 8.
- Zero fields: delay=0, width=0, count=0 → one 1-cycle pulse at k+3.
- Falling edge and invert: cfg_edge=1, cfg_invert=1 → glitch idles high after arm; no response to the rising edge; a 0-pulse follows the falling edge.
- Abort and reset: abort during the 2nd pulse → glitch inactive next cycle, done stays 0, IDLE. Repeat using rst instead of abort → all outputs 0 the next cycle.
- Protocol: arm while busy is ignored (config unchanged). Edges before arm and after done produce no pulse. Trigger held high through reset produces no pulse after arm.

Source files
------------

// File: rtl/glitch_sequencer_pkg.sv
// Shared types and helpers for the glitch sequencer: FSM state encoding,
// trigger-edge selection constants and the zero-to-one field substitution.
package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Wide enough for any counter field; callers cast back to their own width.
  function automatic logic [63:0] clamp1(input logic [63:0] v);
    return (v == 64'd0) ? 64'd1 : v;
  endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Host-side control/status bundle: arm/abort requests, sequence config and
// the armed/busy/done handshake status.
interface glitch_sequencer_if #(
  parameter int CNT_W  = 32,
  parameter int PCNT_W = 8
);
  logic              arm;
  logic              abort;
  logic [CNT_W-1:0]  cfg_delay;
  logic [CNT_W-1:0]  cfg_width;
  logic [CNT_W-1:0]  cfg_gap;
  logic [PCNT_W-1:0] cfg_count;
  logic              cfg_edge;
  logic              cfg_invert;
  logic              armed;
  logic              busy;
  logic              done;

  modport master (
    output arm, abort, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_edge, cfg_invert,
    input  armed, busy, done
  );

  modport slave (
    input  arm, abort, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_edge, cfg_invert,
    output armed, busy, done
  );
endinterface

// File: rtl/glitch_sequencer_trig_sync.sv
// Trigger synchroniser (reset-to-0 flop chain) followed by an edge detector
// producing one-cycle rise and fall strobes.
module trig_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      last <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~last;
  assign fall = ~sync[SYNC_STAGES-1] & last;

endmodule

// File: rtl/glitch_sequencer.sv
// Armed, edge-triggered glitch pulse-train generator. Config is latched at
// arm; outputs are registered one cycle behind the state register.
//
// state | meaning
// IDLE  | waiting for arm; glitch at latched inactive level
// ARMED | config latched, waiting for the selected trigger edge
// DELAY | counting cycles from edge detect to first pulse
// PULSE | glitch active for width cycles
// GAP   | glitch inactive for gap cycles between pulses
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int PCNT_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  glitch_sequencer_if.slave   ctl,
  output logic                glitch
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PCNT_W-1:0] pcnt;
  logic [CNT_W-1:0]  delay_lat;
  logic [CNT_W-1:0]  width_lat;
  logic [CNT_W-1:0]  gap_lat;
  logic [PCNT_W-1:0] count_lat;
  logic              edge_lat;
  logic              inv_lat;
  logic              glitch_q;
  logic              armed_q;
  logic              busy_q;
  logic              done_q;
  logic              fin;
  logic              trig_rise;
  logic              trig_fall;
  logic              edge_hit;
  logic              in_busy;

  trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (trigger),
    .rise (trig_rise),
    .fall (trig_fall)
  );

  assign edge_hit = (edge_lat == EDGE_FALL) ? trig_fall : trig_rise;
  assign in_busy  = (state == ST_DELAY) || (state == ST_PULSE) || (state == ST_GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      delay_lat <= '0;
      width_lat <= '0;
      gap_lat   <= '0;
      count_lat <= '0;
      edge_lat  <= EDGE_RISE;
      inv_lat   <= 1'b0;
      glitch_q  <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin       <= 1'b0;
    end else begin
      fin      <= 1'b0;
      glitch_q <= (state == ST_PULSE && !ctl.abort) ? ~inv_lat : inv_lat;
      armed_q  <= (state == ST_ARMED) && !ctl.abort;
      busy_q   <= in_busy && !ctl.abort;
      // fin lags the last PULSE exit so done rises with the glitch falling edge
      if (fin) done_q <= 1'b1;

      if (ctl.abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ctl.arm) begin
              delay_lat <= ctl.cfg_delay;
              width_lat <= CNT_W'(clamp1(64'(ctl.cfg_width)));
              gap_lat   <= CNT_W'(clamp1(64'(ctl.cfg_gap)));
              count_lat <= PCNT_W'(clamp1(64'(ctl.cfg_count)));
              edge_lat  <= ctl.cfg_edge;
              inv_lat   <= ctl.cfg_invert;
              done_q    <= 1'b0;
              state     <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (edge_hit) begin
              pcnt <= count_lat;
              if (delay_lat == '0) begin
                cnt   <= width_lat;
                state <= ST_PULSE;
              end else begin
                cnt   <= delay_lat;
                state <= ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (cnt == CNT_W'(1)) begin
              cnt   <= width_lat;
              state <= ST_PULSE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_PULSE: begin
            if (cnt == CNT_W'(1)) begin
              if (pcnt == PCNT_W'(1)) begin
                fin   <= 1'b1;
                state <= ST_IDLE;
              end else begin
                pcnt  <= pcnt - PCNT_W'(1);
                cnt   <= gap_lat;
                state <= ST_GAP;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == CNT_W'(1)) begin
              cnt   <= width_lat;
              state <= ST_PULSE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign glitch    = glitch_q;
  assign ctl.armed = armed_q;
  assign ctl.busy  = busy_q;
  assign ctl.done  = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed-vector bench for glitch_sequencer: timing of pulse trains against
// hand-derived edge numbers, plus abort/reset/protocol cases.
module tb_glitch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic glitch;
  int   n_vec = 0;
  int   n_err = 0;

  glitch_sequencer_if #(.CNT_W(32), .PCNT_W(8)) ctl ();

  glitch_sequencer #(.CNT_W(32), .PCNT_W(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .ctl     (ctl),
    .glitch  (glitch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_arm(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                        input logic [7:0] c, input logic e, input logic inv);
    ctl.cfg_delay  = d;
    ctl.cfg_width  = w;
    ctl.cfg_gap    = g;
    ctl.cfg_count  = c;
    ctl.cfg_edge   = e;
    ctl.cfg_invert = inv;
    ctl.arm = 1'b1;
    step();
    ctl.arm = 1'b0;
  endtask

  // Drives trigger to lvl (edge k) and checks every output on edges k+1..end+2.
  // d/w/g/c are the effective (post zero-substitution) values.
  task automatic expect_train(input logic lvl, input int d, input int w, input int g,
                              input int c, input logic inv, input bit meddle);
    int  last_end, act, rel;
    bit  on;
    last_end = 3 + d + c*w + (c-1)*g;
    act = 0;
    trigger = lvl;
    step();
    for (int j = 1; j <= last_end + 2; j++) begin
      step();
      rel = j - 3 - d;
      on  = (rel >= 0) && ((rel / (w+g)) < c) && ((rel % (w+g)) < w);
      if (glitch == ~inv) act++;
      chk($sformatf("glitch@k+%0d", j), {31'd0, glitch}, {31'd0, on ? ~inv : inv});
      chk($sformatf("armed@k+%0d", j), {31'd0, ctl.armed}, {31'd0, j < 3});
      chk($sformatf("busy@k+%0d", j), {31'd0, ctl.busy}, {31'd0, (j >= 3) && (j < last_end)});
      chk($sformatf("done@k+%0d", j), {31'd0, ctl.done}, {31'd0, j >= last_end});
      if (meddle && j == 5) begin
        ctl.cfg_delay = 32'd0; ctl.cfg_width = 32'd1; ctl.cfg_count = 8'd7;
        ctl.cfg_invert = ~inv; ctl.arm = 1'b1;
      end
      if (meddle && j == 6) ctl.arm = 1'b0;
    end
    chk("active_cycles", act, c*w);
  endtask

  initial begin
    ctl.arm = 1'b0; ctl.abort = 1'b0;
    ctl.cfg_delay = '0; ctl.cfg_width = '0; ctl.cfg_gap = '0; ctl.cfg_count = '0;
    ctl.cfg_edge = 1'b0; ctl.cfg_invert = 1'b0;

    // Reset with trigger held high
    trigger = 1'b1; rst = 1'b1;
    steps(3);
    chk("rst_glitch", {31'd0, glitch}, 32'd0);
    chk("rst_armed", {31'd0, ctl.armed}, 32'd0);
    chk("rst_busy", {31'd0, ctl.busy}, 32'd0);
    chk("rst_done", {31'd0, ctl.done}, 32'd0);
    rst = 1'b0;
    steps(4);

    // Basic: delay 10, width 3, count 1; held-high trigger must not fire
    do_arm(32'd10, 32'd3, 32'd0, 8'd1, 1'b0, 1'b0);
    chk("armed_at_a", {31'd0, ctl.armed}, 32'd0);
    step();
    chk("armed_at_a1", {31'd0, ctl.armed}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("held_high_no_pulse", {31'd0, glitch}, 32'd0);
    end
    trigger = 1'b0;
    steps(5);
    chk("fall_ignored_armed", {31'd0, ctl.armed}, 32'd1);
    expect_train(1'b1, 10, 3, 1, 1, 1'b0, 1'b0);

    // Edges after done do nothing
    trigger = 1'b0; steps(4);
    trigger = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_done_no_pulse", {31'd0, glitch}, 32'd0);
    end
    chk("post_done_sticky", {31'd0, ctl.done}, 32'd1);

    // Pulse train: 4 x (width 2, gap 5)
    trigger = 1'b0; steps(4);
    do_arm(32'd2, 32'd2, 32'd5, 8'd4, 1'b0, 1'b0);
    chk("done_cleared_by_arm", {31'd0, ctl.done}, 32'd0);
    expect_train(1'b1, 2, 2, 5, 4, 1'b0, 1'b0);

    // Zero fields -> single 1-cycle pulse at k+3
    trigger = 1'b0; steps(4);
    do_arm(32'd0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b0);
    expect_train(1'b1, 0, 1, 1, 1, 1'b0, 1'b0);

    // Falling edge, inverted output
    trigger = 1'b0; steps(4);
    do_arm(32'd3, 32'd2, 32'd1, 8'd2, 1'b1, 1'b1);
    step();
    chk("inv_idle_high", {31'd0, glitch}, 32'd1);
    trigger = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("inv_rise_ignored", {31'd0, glitch}, 32'd1);
    end
    chk("inv_still_armed", {31'd0, ctl.armed}, 32'd1);
    expect_train(1'b0, 3, 2, 1, 2, 1'b1, 1'b0);

    // Arm and config changes while busy are ignored
    do_arm(32'd0, 32'd4, 32'd2, 8'd2, 1'b0, 1'b0);
    expect_train(1'b1, 0, 4, 2, 2, 1'b0, 1'b1);

    // Abort during the 2nd pulse (pulses on k+4..6, k+9..11)
    trigger = 1'b0; steps(4);
    do_arm(32'd1, 32'd3, 32'd2, 8'd3, 1'b0, 1'b0);
    trigger = 1'b1; step();
    steps(9);
    chk("abort_pre_pulse2", {31'd0, glitch}, 32'd1);
    ctl.abort = 1'b1; step(); ctl.abort = 1'b0;
    chk("abort_glitch", {31'd0, glitch}, 32'd0);
    chk("abort_busy", {31'd0, ctl.busy}, 32'd0);
    chk("abort_armed", {31'd0, ctl.armed}, 32'd0);
    chk("abort_done", {31'd0, ctl.done}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_quiet", {31'd0, glitch}, 32'd0);
    end
    chk("abort_done_later", {31'd0, ctl.done}, 32'd0);

    // Reset during the 2nd pulse
    trigger = 1'b0; steps(4);
    do_arm(32'd1, 32'd3, 32'd2, 8'd3, 1'b0, 1'b0);
    trigger = 1'b1; step();
    steps(9);
    chk("rst_pre_pulse2", {31'd0, glitch}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_glitch", {31'd0, glitch}, 32'd0);
    chk("midrst_busy", {31'd0, ctl.busy}, 32'd0);
    chk("midrst_armed", {31'd0, ctl.armed}, 32'd0);
    chk("midrst_done", {31'd0, ctl.done}, 32'd0);

    // abort beats arm in the same cycle
    steps(3);
    ctl.abort = 1'b1;
    do_arm(32'd0, 32'd1, 32'd1, 8'd1, 1'b0, 1'b0);
    ctl.abort = 1'b0;
    step();
    chk("abort_beats_arm", {31'd0, ctl.armed}, 32'd0);
    trigger = 1'b0; steps(3); trigger = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_beats_arm_quiet", {31'd0, glitch}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
